dds_phase_accumulator_module: RTL and testbench

DDS_PHASE_ACCUMULATOR_MODULE -- requirements
Module: dds_phase_accumulator_module

---
 rtl/dds_pkg.sv | 15 +
 rtl/sample_tick_module.sv | 37 +++
 rtl/dds_phase_accumulator_module.sv | 102 ++++++++++
 tb/tb_dds_phase_accumulator_module.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants and waveform-select encodings for the DDS phase accumulator.
package dds_pkg;

  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned KW_W       = 12;

  typedef enum logic [1:0] {
    WaveSine     = 2'b00,
    WaveSquare   = 2'b01,
    WaveTriangle = 2'b10,
    WaveSaw      = 2'b11
  } wave_sel_e;

endpackage

// File: rtl/sample_tick_module.sv
// Sample-rate divider: emits a one-cycle registered Tick once every SAMPLE_DIV CLK cycles.
module sample_tick_module #(
  parameter int unsigned SAMPLE_DIV = 50
) (
  input  logic CLK,
  input  logic RSTn,
  output logic Tick
);

  localparam int unsigned CntW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (cnt_q == CntLast) begin
      cnt_d = '0;
    end
  end

  // Tick is registered off the terminal count, so the first one lands a full
  // SAMPLE_DIV cycles after the first edge out of reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == CntLast);
    end
  end

  assign Tick = tick_q;

endmodule

// File: rtl/dds_phase_accumulator_module.sv
// DDS phase accumulator: phase stepping per sample tick, sine-ROM addressing and
// waveform shaping (sine/square/triangle/sawtooth) with period-aligned selection changes.
module dds_phase_accumulator_module
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned SAMPLE_DIV = 50
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [KW_W-1:0]   KW,
  input  logic [1:0]        Wave_Sel,
  input  logic [ADDR_W-1:0] Rom_Data,
  output logic [ADDR_W-1:0] Rom_Addr,
  output logic [ADDR_W-1:0] Wave_Out,
  output logic              Sample_Valid,
  output logic              Phase_Wrap
);

  logic tick;

  sample_tick_module #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sample_tick (
    .CLK (CLK),
    .RSTn(RSTn),
    .Tick(tick)
  );

  logic [ACC_W-1:0]  phase_q;
  logic [ACC_W:0]    kw_ext;
  logic [ACC_W:0]    sum;
  logic              carry;
  wave_sel_e         sel_q;
  logic              v1_q, v2_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wave_q, wave_d;
  logic [ADDR_W-1:0] tri_ramp;
  logic              valid_q;
  logic              wrap_q;

  assign kw_ext = {{(ACC_W + 1 - KW_W){1'b0}}, KW};
  assign sum    = {1'b0, phase_q} + kw_ext;
  assign carry  = sum[ACC_W];

  assign Rom_Addr = phase_q[ACC_W-1 -: ADDR_W];

  // Selection reloads only on a wrapping tick so shape changes land on period boundaries.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      phase_q <= '0;
      sel_q   <= WaveSine;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= tick & carry;
      if (tick) begin
        phase_q <= sum[ACC_W-1:0];
        if (carry) begin
          sel_q <= wave_sel_e'(Wave_Sel);
        end
      end
    end
  end

  always_comb begin
    tri_ramp = {addr_q[ADDR_W-2:0], 1'b0};
    wave_d   = Rom_Data;
    unique case (sel_q)
      WaveSine:     wave_d = Rom_Data;
      WaveSquare:   wave_d = addr_q[ADDR_W-1] ? '1 : '0;
      // All-ones minus the ramp is its bitwise complement.
      WaveTriangle: wave_d = addr_q[ADDR_W-1] ? ~tri_ramp : tri_ramp;
      WaveSaw:      wave_d = addr_q;
      default:      wave_d = Rom_Data;
    endcase
  end

  // addr_q trails Rom_Addr by one cycle to line up with the synchronous ROM output.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      addr_q  <= '0;
      wave_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      v1_q    <= tick;
      v2_q    <= v1_q;
      addr_q  <= Rom_Addr;
      valid_q <= v2_q;
      if (v2_q) begin
        wave_q <= wave_d;
      end
    end
  end

  assign Wave_Out     = wave_q;
  assign Sample_Valid = valid_q;
  assign Phase_Wrap   = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator_module.sv
// Bench for dds_phase_accumulator_module: segment table plus tick-level scoreboard.
module tb_dds_phase_accumulator_module;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [11:0] KW = '0;
  logic [1:0] Wave_Sel = '0;
  logic [9:0] Rom_Data = '0;
  logic [9:0] Rom_Addr;
  logic [9:0] Wave_Out;
  logic       Sample_Valid;
  logic       Phase_Wrap;

  always #5 CLK = ~CLK;

  // ROM model: returns the address as data, one cycle later.
  always @(posedge CLK) Rom_Data <= Rom_Addr;

  dds_phase_accumulator_module #(
    .ACC_W(20),
    .ADDR_W(10),
    .SAMPLE_DIV(4)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .KW          (KW),
    .Wave_Sel    (Wave_Sel),
    .Rom_Data    (Rom_Data),
    .Rom_Addr    (Rom_Addr),
    .Wave_Out    (Wave_Out),
    .Sample_Valid(Sample_Valid),
    .Phase_Wrap  (Phase_Wrap)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] wave_f(input logic [1:0] s, input logic [9:0] a);
    logic [9:0] t;
    t = {a[8:0], 1'b0};
    case (s)
      2'b00:   return a;
      2'b01:   return a[9] ? 10'd1023 : 10'd0;
      2'b10:   return a[9] ? (10'd1023 - t) : t;
      default: return a;
    endcase
  endfunction

  typedef struct {
    int         due;
    logic [1:0] sel;
    logic [9:0] addr;
    logic [9:0] wave;
  } sb_t;

  typedef struct {
    logic [1:0] sel;
    logic [9:0] addr;
    logic [9:0] exp;
  } pt_t;

  typedef struct {
    logic [11:0] kw;
    logic [1:0]  sel;
    int          ticks;
    logic [9:0]  exp_addr;
    int          exp_wraps;
  } seg_t;

  sb_t        q[$];
  sb_t        e;
  pt_t        pts[8];
  seg_t       segs[9];
  int         ecnt;
  int         wrap_seen;
  logic [19:0] mphase;
  logic [20:0] msum;
  logic [1:0] msel;
  logic       exp_wrap;
  logic       sv_exp;

  // Tick-level model and monitor; each negedge follows exactly one posedge.
  initial begin
    ecnt = 0; mphase = '0; msel = '0; exp_wrap = 1'b0; wrap_seen = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        ecnt = 0; mphase = '0; msel = '0; exp_wrap = 1'b0;
        q.delete();
        chk("reset rom_addr", Rom_Addr, 0);
        chk("reset wave_out", Wave_Out, 0);
        chk("reset sample_valid", Sample_Valid, 0);
        chk("reset phase_wrap", Phase_Wrap, 0);
      end else begin
        ecnt++;
        exp_wrap = 1'b0;
        if (ecnt > 1 && ecnt % 4 == 1) begin
          msum = {1'b0, mphase} + {9'd0, KW};
          mphase = msum[19:0];
          exp_wrap = msum[20];
          if (msum[20]) msel = Wave_Sel;
          q.push_back('{ecnt + 2, msel, mphase[19:10], wave_f(msel, mphase[19:10])});
        end
        chk("rom_addr", Rom_Addr, mphase[19:10]);
        chk("phase_wrap", Phase_Wrap, exp_wrap);
        if (Phase_Wrap) wrap_seen++;
        sv_exp = 1'b0;
        if (q.size() != 0) sv_exp = (q[0].due == ecnt);
        chk("sample_valid", Sample_Valid, sv_exp);
        if (sv_exp) begin
          e = q.pop_front();
          chk("wave_out", Wave_Out, e.wave);
          for (int i = 0; i < 8; i++) begin
            if (pts[i].sel == e.sel && pts[i].addr == e.addr)
              chk("wave_point", Wave_Out, pts[i].exp);
          end
        end
      end
    end
  end

  int n;

  initial begin
    pts[0] = '{2'b01, 10'd511, 10'd0};
    pts[1] = '{2'b01, 10'd512, 10'd1023};
    pts[2] = '{2'b10, 10'd256, 10'd512};
    pts[3] = '{2'b10, 10'd768, 10'd511};
    pts[4] = '{2'b00, 10'd300, 10'd300};
    pts[5] = '{2'b00, 10'd400, 10'd400};
    pts[6] = '{2'b01, 10'd2,   10'd0};
    pts[7] = '{2'b11, 10'd5,   10'd5};

    segs[0] = '{12'd1024, 2'b11, 10,   10'd10,  0};
    segs[1] = '{12'd0,    2'b11, 5,    10'd10,  0};
    segs[2] = '{12'd1024, 2'b01, 1014, 10'd0,   1};
    segs[3] = '{12'd1024, 2'b10, 1024, 10'd0,   1};
    segs[4] = '{12'd1024, 2'b00, 1024, 10'd0,   1};
    segs[5] = '{12'd1024, 2'b00, 300,  10'd300, 0};
    segs[6] = '{12'd1024, 2'b01, 724,  10'd0,   1};
    segs[7] = '{12'd1024, 2'b01, 3,    10'd3,   0};
    segs[8] = '{12'd1024, 2'b01, 697,  10'd700, 0};

    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    RSTn = 1'b1;
    @(negedge CLK);
    #1;

    for (int i = 0; i < 9; i++) begin
      KW = segs[i].kw;
      Wave_Sel = segs[i].sel;
      wrap_seen = 0;
      repeat (4 * segs[i].ticks) @(negedge CLK);
      #1;
      chk("segment rom_addr", Rom_Addr, segs[i].exp_addr);
      chk("segment wraps", wrap_seen, segs[i].exp_wraps);
    end

    // Mid-period reset: sample pulse of the last tick is in flight right now.
    repeat (2) @(negedge CLK);
    #1;
    chk("pre-reset rom_addr", Rom_Addr, 700);
    RSTn = 1'b0;
    #1;
    chk("async rst rom_addr", Rom_Addr, 0);
    chk("async rst wave_out", Wave_Out, 0);
    chk("async rst sample_valid", Sample_Valid, 0);
    chk("async rst phase_wrap", Phase_Wrap, 0);
    repeat (3) @(negedge CLK);
    #1;
    KW = 12'd1024;
    Wave_Sel = 2'b01;
    RSTn = 1'b1;
    n = 0;
    while (!Sample_Valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("first valid latency", n, 7);
    chk("post-reset sine sample", Wave_Out, 1);

    repeat (40) @(negedge CLK);
    #1;
    chk("restart rom_addr", Rom_Addr, 11);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
